// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, DATA_BITS data bits LSB first, stop bit, CLKS_PER_BIT clocks per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8
) (
    input  logic                 tx_clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 data_out,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign bit_end  = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign data_out = tx_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // The line level is computed one state ahead so data_out stays a plain flop.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (!en && state_q != IDLE) begin
            state_d   = IDLE;
            clk_cnt_d = '0;
            bit_idx_d = '0;
            tx_d      = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_d      = 1'b1;
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    if (en && start) begin
                        state_d  = START;
                        shift_d  = data_in;
                        tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^data_in;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt_d = '0;
                        state_d   = DATA;
                        tx_d      = shift_q[0];
                    end else begin
                        clk_cnt_d = clk_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt_d = '0;
                        shift_d   = shift_q >> 1;
                        if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                            state_d   = PARITY;
                            tx_d      = parity_q;
`else
                            state_d   = STOP;
                            tx_d      = 1'b1;
`endif
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                            tx_d      = shift_d[0];
                        end
                    end else begin
                        clk_cnt_d = clk_cnt_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        clk_cnt_d = '0;
                        state_d   = STOP;
                        tx_d      = 1'b1;
                    end else begin
                        clk_cnt_d = clk_cnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        clk_cnt_d = '0;
                        state_d   = IDLE;
                        tx_d      = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        clk_cnt_d = clk_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    tx_d      = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial UART transmitter, the counterpart of uart_rx. Accepts a parallel byte on a single-cycle start pulse and shifts it out as one 8N1 frame: start bit, 8 data bits LSB first, stop bit. Each bit lasts CLKS_PER_BIT clocks, which is 8 by default and matches the receiver's bit timing. It sits on the transmit side of the UART link, driven by the same host logic that consumes uart_rx output.

Parameters:
CLKS_PER_BIT, 8, tx_clk cycles per serial bit (min 2)
DATA_BITS, 8, data bits per frame (fixed width of data_in)

Ports:
tx_clk  input  1  transmit clock; all logic rising-edge
rst_n  input  1  asynchronous, active-low reset
en  input  1  block enable; low blocks new frames and aborts an active frame
start  input  1  single-cycle request to send data_in
data_in  input  DATA_BITS  parallel byte, sampled on the accepted start
data_out  output  1  serial line; idles high
busy  output  1  high while a frame is in progress
done  output  1  one-cycle pulse after the stop bit completes

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; data_out=1, busy=0, done=0; bit counter, clock counter and shift register all cleared.
- Reset mid-frame: line returns high immediately; no done pulse.
- States: IDLE -> START -> DATA -> STOP -> IDLE. With UART_TX_PARITY_EN, DATA -> PARITY -> STOP.
- Acceptance: start=1, en=1 and state IDLE on edge N.
  - data_in is latched into the shift register.
  - On edge N, state goes to START, data_out goes 0 and busy goes 1.
  - Latency from accepted start to line low: one edge.
- Ignored start: when busy=1 or en=0, start is dropped with no queuing. data_in changes after acceptance have no effect.
- Bit timing:
  - Clock counter runs 0..CLKS_PER_BIT-1 per bit; the bit advances on the terminal count.
  - Each bit is held exactly CLKS_PER_BIT cycles.
- DATA: data_out = shift[0]; shift right each bit. Bit index 0..DATA_BITS-1; leave DATA after index DATA_BITS-1.
- STOP: data_out=1 for CLKS_PER_BIT cycles. Then:
  - state returns to IDLE and busy drops to 0;
  - done=1 for exactly one cycle, on that same edge.
- Frame length: (2+DATA_BITS)*CLKS_PER_BIT cycles, which is 80 by default. busy is high for exactly that many cycles.
- Back-to-back frames: start may be accepted in the cycle done is high. The next start bit then begins on the following edge, with no extra idle bit.
- en deasserted mid-frame: abort on the next edge.
  - State goes to IDLE; data_out=1, busy=0, no done.
  - Counters are cleared.
- en low in IDLE: line held high; outputs unchanged.
- data_out is a registered output, glitch-free.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted after DATA.
  - It drives the even-parity bit (XOR of the latched data) for CLKS_PER_BIT cycles.
  - Frame length becomes (3+DATA_BITS)*CLKS_PER_BIT, which is 88 by default.
- Undefined: no PARITY state and no parity logic; 8N1 framing only.

Test Plan:
- Reset, then hold rst_n low for 3 cycles mid-idle -> data_out=1, busy=0, done=0 throughout.
- en=1, pulse start with data_in=0xA5 -> line low 8 cycles (start bit); data bits 1,0,1,0,0,1,0,1 at 8 cycles each; high 8 cycles (stop bit). busy high 80 cycles, done pulses once as busy falls. The uart_rx bench loopback recovers 0xA5.
- Pulse start again at cycle 20 of the 0xA5 frame with data_in=0x3C -> ignored; frame remains 0xA5; exactly one done pulse.
- Send 0x00, then re-pulse start with 0xFF in the done cycle -> second start bit begins on the next edge; stop bit of frame 1 is exactly 8 cycles; both frames decode correctly.
- Drop en at cycle 30 of a 0x5A frame -> next edge data_out=1, busy=0, no done. A new start with en=1 then sends a full 80-cycle frame.
- With UART_TX_PARITY_EN, send 0x07 -> parity bit 1 after the data bits; busy high 88 cycles. Send 0x03 -> parity bit 0.
